// File: rtl/vga_grid_renderer.sv
// vga_grid_renderer: COLS x ROWS game-cell grid on a 640x480@60 VGA raster.
// Inputs are shadowed at vblank, hit cells flash green. Optional macro GRID_BORDER_EN draws white cell borders.
module vga_grid_renderer #(
    parameter int unsigned COLS         = 3,
    parameter int unsigned ROWS         = 3,
    parameter int unsigned CELL_W       = 80,
    parameter int unsigned CELL_H       = 80,
    parameter int unsigned ORIGIN_X     = 100,
    parameter int unsigned ORIGIN_Y     = 60,
    parameter int unsigned FLASH_FRAMES = 8,
    parameter int unsigned CLK_DIV      = 4,
    parameter int unsigned H_VIS        = 640,
    parameter int unsigned H_FP         = 16,
    parameter int unsigned H_SYNC       = 96,
    parameter int unsigned H_BP         = 48,
    parameter int unsigned V_VIS        = 480,
    parameter int unsigned V_FP         = 10,
    parameter int unsigned V_SYNC       = 2,
    parameter int unsigned V_BP         = 33
) (
    input  logic                 CLK,
    input  logic                 RST_BTN,
    input  logic [COLS*ROWS-1:0] target,
    input  logic [COLS*ROWS-1:0] hit,
    output logic                 frame_start,
    output logic                 VGA_HS_O,
    output logic                 VGA_VS_O,
    output logic [3:0]           VGA_R,
    output logic [3:0]           VGA_G,
    output logic [3:0]           VGA_B
);
    localparam int unsigned CELLS   = COLS * ROWS;
    localparam int unsigned H_TOT   = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT   = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int unsigned H_W     = $clog2(H_TOT);
    localparam int unsigned V_W     = $clog2(V_TOT);
    localparam int unsigned DIV_W   = $clog2(CLK_DIV);
    localparam int unsigned SX_W    = (CELL_W > 1) ? $clog2(CELL_W) : 1;
    localparam int unsigned SY_W    = (CELL_H > 1) ? $clog2(CELL_H) : 1;
    localparam int unsigned COL_W   = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned CELL_IW = (CELLS > 1) ? $clog2(CELLS) : 1;

    logic [DIV_W-1:0]   div_cnt;
    logic               pix_stb_c;
    logic [H_W-1:0]     h, h_nxt_c;
    logic [V_W-1:0]     v, v_nxt_c;
    logic               h_wrap_c;
    logic [SX_W-1:0]    sx, sx_nxt_c;
    logic [SY_W-1:0]    sy, sy_nxt_c;
    logic [COL_W-1:0]   col, col_nxt_c;
    logic [ROW_W-1:0]   row, row_nxt_c;
    logic               in_x, in_x_nxt_c, in_y, in_y_nxt_c;
    logic               sample_c;
    logic [CELLS-1:0]   target_sh;
    logic [3:0]         flash [CELLS];
    logic               blank1, grid1, hs1, vs1;
    logic [CELL_IW-1:0] cell1;
    logic [3:0]         r_c, g_c, b_c;
`ifdef GRID_BORDER_EN
    logic               border1;
`endif

    assign pix_stb_c = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign sample_c  = pix_stb_c && (h == '0) && (v == V_W'(V_VIS));

    always_ff @(posedge CLK or negedge RST_BTN) begin
        if (!RST_BTN) div_cnt <= '0;
        else          div_cnt <= div_cnt + DIV_W'(1);
    end

    // Next raster position plus incremental cell sub-counters (no dividers)
    always_comb begin
        h_wrap_c   = (h == H_W'(H_TOT - 1));
        h_nxt_c    = h_wrap_c ? '0 : h + H_W'(1);
        v_nxt_c    = v;
        in_x_nxt_c = in_x;
        sx_nxt_c   = sx;
        col_nxt_c  = col;
        in_y_nxt_c = in_y;
        sy_nxt_c   = sy;
        row_nxt_c  = row;
        if (h_nxt_c == H_W'(ORIGIN_X)) begin
            in_x_nxt_c = 1'b1;
            sx_nxt_c   = '0;
            col_nxt_c  = '0;
        end else if (h_nxt_c == '0) begin
            in_x_nxt_c = 1'b0;
        end else if (in_x) begin
            if (sx == SX_W'(CELL_W - 1)) begin
                sx_nxt_c = '0;
                if (col == COL_W'(COLS - 1)) in_x_nxt_c = 1'b0;
                else                         col_nxt_c  = col + COL_W'(1);
            end else begin
                sx_nxt_c = sx + SX_W'(1);
            end
        end
        if (h_wrap_c) begin
            v_nxt_c = (v == V_W'(V_TOT - 1)) ? '0 : v + V_W'(1);
            if (v_nxt_c == V_W'(ORIGIN_Y)) begin
                in_y_nxt_c = 1'b1;
                sy_nxt_c   = '0;
                row_nxt_c  = '0;
            end else if (v_nxt_c == '0) begin
                in_y_nxt_c = 1'b0;
            end else if (in_y) begin
                if (sy == SY_W'(CELL_H - 1)) begin
                    sy_nxt_c = '0;
                    if (row == ROW_W'(ROWS - 1)) in_y_nxt_c = 1'b0;
                    else                         row_nxt_c  = row + ROW_W'(1);
                end else begin
                    sy_nxt_c = sy + SY_W'(1);
                end
            end
        end
    end

    // S0: raster counters
    always_ff @(posedge CLK or negedge RST_BTN) begin
        if (!RST_BTN) begin
            h    <= '0;
            v    <= '0;
            sx   <= '0;
            sy   <= '0;
            col  <= '0;
            row  <= '0;
            in_x <= (ORIGIN_X == 0);
            in_y <= (ORIGIN_Y == 0);
        end else if (pix_stb_c) begin
            h    <= h_nxt_c;
            v    <= v_nxt_c;
            sx   <= sx_nxt_c;
            sy   <= sy_nxt_c;
            col  <= col_nxt_c;
            row  <= row_nxt_c;
            in_x <= in_x_nxt_c;
            in_y <= in_y_nxt_c;
        end
    end

    // Vblank sampling of the game inputs
    always_ff @(posedge CLK or negedge RST_BTN) begin
        if (!RST_BTN) begin
            target_sh   <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= sample_c;
            if (sample_c) target_sh <= target;
        end
    end

    for (genvar i = 0; i < int'(CELLS); i++) begin : g_flash
        always_ff @(posedge CLK or negedge RST_BTN) begin
            if (!RST_BTN)                 flash[i] <= 4'd0;
            else if (sample_c && hit[i])  flash[i] <= 4'(FLASH_FRAMES);
            else if (sample_c && flash[i] != 4'd0) flash[i] <= flash[i] - 4'd1;
        end
    end

    // S1: cell decode and sync compare
    always_ff @(posedge CLK or negedge RST_BTN) begin
        if (!RST_BTN) begin
            blank1  <= 1'b1;
            grid1   <= 1'b0;
            cell1   <= '0;
            hs1     <= 1'b1;
            vs1     <= 1'b1;
`ifdef GRID_BORDER_EN
            border1 <= 1'b0;
`endif
        end else if (pix_stb_c) begin
            blank1  <= !((h < H_W'(H_VIS)) && (v < V_W'(V_VIS)));
            grid1   <= in_x && in_y;
            cell1   <= CELL_IW'(row) * CELL_IW'(COLS) + CELL_IW'(col);
            hs1     <= !((h >= H_W'(H_VIS + H_FP)) && (h < H_W'(H_VIS + H_FP + H_SYNC)));
            vs1     <= !((v >= V_W'(V_VIS + V_FP)) && (v < V_W'(V_VIS + V_FP + V_SYNC)));
`ifdef GRID_BORDER_EN
            border1 <= (sx == '0) || (sx == SX_W'(CELL_W - 1)) ||
                       (sy == '0) || (sy == SY_W'(CELL_H - 1));
`endif
        end
    end

    // Colour priority: blank/outside, border, flash, target, idle red
    always_comb begin
        r_c = 4'h0;
        g_c = 4'h0;
        b_c = 4'h0;
        if (!blank1 && grid1) begin
`ifdef GRID_BORDER_EN
            if (border1) begin
                r_c = 4'hF;
                g_c = 4'hF;
                b_c = 4'hF;
            end else
`endif
            if (flash[cell1] != 4'd0) begin
                g_c = 4'hF;
            end else if (target_sh[cell1]) begin
                r_c = 4'hF;
                g_c = 4'hF;
            end else begin
                r_c = 4'h8;
            end
        end
    end

    // S2: registered VGA outputs
    always_ff @(posedge CLK or negedge RST_BTN) begin
        if (!RST_BTN) begin
            VGA_HS_O <= 1'b1;
            VGA_VS_O <= 1'b1;
            VGA_R    <= 4'h0;
            VGA_G    <= 4'h0;
            VGA_B    <= 4'h0;
        end else if (pix_stb_c) begin
            VGA_HS_O <= hs1;
            VGA_VS_O <= vs1;
            VGA_R    <= r_c;
            VGA_G    <= g_c;
            VGA_B    <= b_c;
        end
    end
endmodule

// File: tb/tb_vga_grid_renderer.sv
// tb_vga_grid_renderer: directed scoreboard bench on a reduced 40x30 raster so many frames
// fit in a short run. Grid: 3x3 cells of 6x4 px at (4,2); CLK_DIV=2; flash lasts 3 frames.
`timescale 1ns/1ps
module tb_vga_grid_renderer;
    localparam int HT     = 40;
    localparam int FR     = 1200;
    localparam int FS_CLK = 1922;   // CLK count of first frame_start: 2*(24*40+1)
    localparam int FR_CLK = 2400;

    typedef struct {
        int       idx;
        logic [3:0] r, g, b;
        logic     hs, vs;
        string    name;
    } exp_t;

    logic       CLK = 1'b0;
    logic       RST_BTN = 1'b0;
    logic [8:0] target = '0;
    logic [8:0] hit = '0;
    logic       frame_start, VGA_HS_O, VGA_VS_O;
    logic [3:0] VGA_R, VGA_G, VGA_B;

    int   clk_n = 0;
    int   total = 0;
    int   bad = 0;
    int   fs_seen = 0;
    exp_t q[$];
    exp_t e;
    int   n;
    logic fs_exp;

    vga_grid_renderer #(
        .COLS(3), .ROWS(3), .CELL_W(6), .CELL_H(4), .ORIGIN_X(4), .ORIGIN_Y(2),
        .FLASH_FRAMES(3), .CLK_DIV(2),
        .H_VIS(32), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_VIS(24), .V_FP(2), .V_SYNC(2), .V_BP(2)
    ) dut (
        .CLK(CLK), .RST_BTN(RST_BTN), .target(target), .hit(hit),
        .frame_start(frame_start), .VGA_HS_O(VGA_HS_O), .VGA_VS_O(VGA_VS_O),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK or negedge RST_BTN) begin
        if (!RST_BTN) clk_n <= 0;
        else          clk_n <= clk_n + 1;
    end

    function automatic void expect_px(int f, int h, int v, logic [3:0] r, logic [3:0] g,
                                      logic [3:0] b, logic hs, logic vs, string name);
        exp_t x;
        int   pos;
        x.idx = f * FR + v * HT + h;
        x.r = r; x.g = g; x.b = b; x.hs = hs; x.vs = vs; x.name = name;
        pos = 0;
        while (pos < q.size() && q[pos].idx <= x.idx) pos++;
        q.insert(pos, x);
    endfunction

    function automatic void expect_rgb(int f, int h, int v, logic [3:0] r, logic [3:0] g,
                                       logic [3:0] b, string name);
        expect_px(f, h, v, r, g, b, 1'b1, 1'b1, name);
    endfunction

    task automatic chk(string name, logic [14:0] got, logic [14:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // Scoreboard monitor: after strobe s the outputs show pixel index s-2
    always @(negedge CLK) begin
        if (RST_BTN === 1'b1) begin
            if (clk_n >= 4 && clk_n % 2 == 0) begin
                n = clk_n / 2 - 2;
                while (q.size() > 0 && q[0].idx <= n) begin
                    e = q.pop_front();
                    total++;
                    if (e.idx != n) begin
                        bad++;
                        $display("FAIL %s missed idx=%0d now=%0d", e.name, e.idx, n);
                    end else if ({VGA_R, VGA_G, VGA_B, VGA_HS_O, VGA_VS_O} !==
                                 {e.r, e.g, e.b, e.hs, e.vs}) begin
                        bad++;
                        $display("FAIL %s got rgb=%h%h%h hs=%b vs=%b want rgb=%h%h%h hs=%b vs=%b",
                                 e.name, VGA_R, VGA_G, VGA_B, VGA_HS_O, VGA_VS_O,
                                 e.r, e.g, e.b, e.hs, e.vs);
                    end
                end
            end
            fs_exp = (clk_n >= FS_CLK) && ((clk_n - FS_CLK) % FR_CLK == 0);
            if (frame_start || fs_exp) begin
                total++;
                if (frame_start !== fs_exp) begin
                    bad++;
                    $display("FAIL frame_start at clk=%0d got=%b want=%b", clk_n, frame_start, fs_exp);
                end
                if (frame_start) fs_seen++;
            end
        end
    end

    task automatic wait_clk(int c);
        while (clk_n < c) @(negedge CLK);
    endtask

    task automatic wait_s0(int idx);
        while (clk_n / 2 < idx) @(negedge CLK);
    endtask

    task automatic mid_reset(string name);
        #2 RST_BTN = 1'b0;
        #1 chk(name, {frame_start, VGA_HS_O, VGA_VS_O, VGA_R, VGA_G, VGA_B}, 15'b0_1_1_000000000000);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL %s leftover got=%0d want=0", name, q.size());
            q.delete();
        end
        @(negedge CLK) RST_BTN = 1'b1;
    endtask

    task automatic pulse_hit(int f, logic [8:0] m);
        wait_s0(f * FR + 22 * HT);
        hit = m;
        wait_s0(f * FR + 25 * HT);
        hit = '0;
    endtask

    initial begin
        int fs_want;
        #12 chk("reset_vals", {frame_start, VGA_HS_O, VGA_VS_O, VGA_R, VGA_G, VGA_B}, 15'b0_1_1_000000000000);

        // Phase A: reset mid-frame while an idle red cell pixel is on the pins
        expect_rgb(0, 6, 3, 4'h8, 4'h0, 4'h0, "a_cell0_red");
        @(negedge CLK) RST_BTN = 1'b1;
        wait_clk(2 * (3 * HT + 6 + 2));
        mid_reset("rst_mid_rgb");

        // Phase A2: first HS low 34+2 strobes after release, then reset while HS is low
        expect_px(0, 33, 0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1, "first_hs_high");
        expect_px(0, 34, 0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1, "first_hs_low");
        expect_px(0, 35, 1, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1, "a2_hs_low");
        wait_clk(2 * (HT + 35 + 2));
        target = 9'b000010000;
        mid_reset("rst_mid_hs");

        // Phase B frame 0: shadows still empty, sync edges
        expect_rgb(0, 5, 3, 4'h8, 4'h0, 4'h0, "f0_cell0");
        expect_rgb(0, 3, 3, 4'h0, 4'h0, 4'h0, "f0_left_out");
        expect_rgb(0, 12, 7, 4'h8, 4'h0, 4'h0, "f0_cell4_not_sampled");
        expect_px(0, 37, 0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1, "hs_last_low");
        expect_px(0, 38, 0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1, "hs_after");
        expect_px(0, 0, 25, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1, "vs_before");
        expect_px(0, 0, 26, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, "vs_first");
        expect_px(0, 34, 26, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, "hs_vs_both");
        expect_px(0, 39, 27, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, "vs_last");
        expect_px(0, 0, 28, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1, "vs_after");

        // Frame 1: target[4] visible
        expect_rgb(1, 12, 7, 4'hF, 4'hF, 4'h0, "f1_cell4_yellow");
        expect_rgb(1, 5, 3, 4'h8, 4'h0, 4'h0, "f1_cell0_red");
        expect_rgb(1, 2, 3, 4'h0, 4'h0, 4'h0, "f1_left_out");
        expect_rgb(1, 22, 7, 4'h0, 4'h0, 4'h0, "f1_right_out");
        expect_rgb(1, 21, 13, 4'h8, 4'h0, 4'h0, "f1_cell8_corner");
        expect_rgb(1, 4, 13, 4'h8, 4'h0, 4'h0, "f1_cell6_corner");
        expect_rgb(1, 4, 14, 4'h0, 4'h0, 4'h0, "f1_below_grid");
        expect_px(1, 34, 5, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1, "f1_hs_low");

        // Hit flash on cell 0 sampled at end of frame 1: green frames 2..4
        expect_rgb(2, 5, 3, 4'h0, 4'hF, 4'h0, "flash_f2");
        expect_rgb(4, 5, 3, 4'h0, 4'hF, 4'h0, "flash_f4");
        expect_rgb(5, 5, 3, 4'h8, 4'h0, 4'h0, "flash_over_f5");
        expect_rgb(6, 5, 3, 4'h8, 4'h0, 4'h0, "flash_over_f6");
        pulse_hit(1, 9'b000000001);

        // Simultaneous target[8] and hit[8]: green wins over yellow
        expect_rgb(2, 18, 11, 4'h8, 4'h0, 4'h0, "c8_before");
        expect_rgb(3, 18, 11, 4'h0, 4'hF, 4'h0, "c8_green_f3");
        expect_rgb(5, 18, 11, 4'h0, 4'hF, 4'h0, "c8_green_f5");
        expect_rgb(6, 18, 11, 4'hF, 4'hF, 4'h0, "c8_yellow_f6");
        wait_s0(2 * FR + 22 * HT);
        target[8] = 1'b1;
        pulse_hit(2, 9'b100000000);

        // target[2] toggled early in frame 4: unchanged until frame 5
        expect_rgb(3, 17, 4, 4'h8, 4'h0, 4'h0, "c2_f3");
        expect_rgb(4, 17, 4, 4'h8, 4'h0, 4'h0, "c2_f4_no_tear");
        expect_rgb(5, 17, 4, 4'hF, 4'hF, 4'h0, "c2_f5_yellow");
        wait_s0(4 * FR + HT);
        target[2] = 1'b1;

        // Re-hit during flash restarts the count
        expect_rgb(7, 5, 3, 4'h0, 4'hF, 4'h0, "rehit_f7");
        expect_rgb(8, 5, 3, 4'h0, 4'hF, 4'h0, "rehit_f8");
        expect_rgb(10, 5, 3, 4'h0, 4'hF, 4'h0, "rehit_f10");
        expect_rgb(11, 5, 3, 4'h0, 4'hF, 4'h0, "rehit_f11");
        expect_rgb(12, 5, 3, 4'h8, 4'h0, 4'h0, "rehit_over_f12");
        expect_rgb(12, 12, 7, 4'hF, 4'hF, 4'h0, "f12_cell4_yellow");
        pulse_hit(6, 9'b000000001);
        pulse_hit(8, 9'b000000001);

        while (q.size() > 0 && clk_n < 2 * 13 * FR) @(negedge CLK);
        #1;
        if (q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL timeout pending got=%0d want=0", q.size());
        end
        fs_want = (clk_n >= FS_CLK) ? (clk_n - FS_CLK) / FR_CLK + 1 : 0;
        total++;
        if (fs_seen != fs_want) begin
            bad++;
            $display("FAIL frame_start_count got=%0d want=%0d", fs_seen, fs_want);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/vga_grid_renderer.md
# vga_grid_renderer

Parametrised successor to the single-board square renderer. It draws a COLS×ROWS grid of game cells on a 640×480@60 Hz VGA display. It integrates the pixel strobe, the sync generator, per-cell target/hit state with frame-synchronous shadowing, and a multi-frame hit-flash effect. It sits between the game logic (target and hit vectors) and the board VGA pins.

## Interface
- COLS, 3: grid columns (1..8)
- ROWS, 3: grid rows (1..6)
- CELL_W, 80: cell width in pixels
- CELL_H, 80: cell height in pixels
- ORIGIN_X, 100: left edge of cell column 0
- ORIGIN_Y, 60: top edge of cell row 0
- FLASH_FRAMES, 8: frames a hit cell stays green (1..15)
- CLK_DIV, 4: CLK cycles per pixel strobe (power of two, ≥2)

- CLK  in  1  system clock, 100 MHz
- RST_BTN  in  1  asynchronous active-low reset
- target  in  COLS*ROWS  per-cell lit flag; bit index = row*COLS+col
- hit  in  COLS*ROWS  per-cell hit flag; same indexing
- frame_start  out  1  one-CLK pulse when inputs are sampled
- VGA_HS_O  out  1  horizontal sync, active low
- VGA_VS_O  out  1  vertical sync, active low
- VGA_R, VGA_G, VGA_B  out  4 each  colour

## Operation
- Reset values: HS=1, VS=1, RGB=0, frame_start=0. Reset also clears all counters, shadows and flash counters. Reset is asynchronous and takes effect mid-frame immediately. After release, h=0 and v=0.
- Strobe: a divider produces pix_stb high for 1 CLK every CLK_DIV CLKs. All pixel-domain state advances only on pix_stb.
- Horizontal counter h runs 0..799 and wraps. Vertical counter v increments on h wrap and runs 0..524. Active region is h<640 and v<480.
- HS is low for h in 656..751. VS is low for v in 490..491.
- Sampling: on the strobe where h=0 and v=480 (start of vblank), target and hit are copied into shadow registers, and frame_start pulses on that CLK. Rendering uses only the shadows, so there is no tearing.
- Flash counter per cell (4 bits), updated at the sampling strobe:
  - hit=1: load FLASH_FRAMES. This applies even while the cell is already flashing.
  - hit=0 and counter nonzero: decrement.
- Cell decode: a pixel is inside the grid when ORIGIN_X ≤ h < ORIGIN_X+COLS*CELL_W and ORIGIN_Y ≤ v < ORIGIN_Y+ROWS*CELL_H.
  - col = (h−ORIGIN_X)/CELL_W and row = (v−ORIGIN_Y)/CELL_H.
  - Both are computed with incremental sub-counters. No dividers.
- Colour priority, in order:
  1. Blanking → 0,0,0
  2. Outside grid → 0,0,0
  3. Flash nonzero → G=F, R=0, B=0
  4. Target shadow set → R=F, G=F, B=0
  5. Otherwise → R=8, G=0, B=0
- A grid that extends past 640/480 is clipped by blanking. It does not wrap.

## Timing
- Three-stage pixel pipeline clocked by pix_stb:
  - S0: counters.
  - S1: cell decode plus sync compare.
  - S2: registered outputs.
- RGB, HS and VS for counter value (h,v) appear 2 strobes after S0 holds (h,v). HS and VS are delayed by the same amount, so they stay aligned with RGB.
- Outputs change only on the CLK edge where pix_stb=1.
- frame_start is not pipelined. A shadow update is first visible at v=0 of the next frame.
- Frame period is 800×525 strobes, which is 1,680,000 CLK at CLK_DIV=4.

## Configuration
- GRID_BORDER_EN:
  - Defined: the outermost pixel row and column of every cell (h or v at a cell boundary sub-counter of 0 or CELL_W−1/CELL_H−1) render white (F,F,F). This overrides rule 3 onwards.
  - Undefined: no border logic; cells are solid.

## Test plan
- Reset mid-frame: assert RST_BTN=0 at v=200. HS=VS=1 and RGB=0 within the same CLK. After release, the first HS low comes 656+2 strobes later.
- Sync timing, defaults, 2 frames, RST_BTN=1: HS low 96 strobes per line, period 800. VS low 2 lines per frame, period 525 lines. frame_start pulses every 1,680,000 CLK.
- Target render: target=9'b000010000. At the next frame, pixel (220,180) (cell 4) is R=F,G=F. Pixel (120,80) (cell 0) is R=8,G=0. Pixel (50,80) is black.
- Hit flash: pulse hit[0]=1 across one sampling strobe. Cell 0 is green for exactly 8 frames, then red 8. Re-hit at frame 5 restarts to 8 more frames.
- Simultaneous: target[8]=1 and hit[8]=1. Cell 8 (x 260..339, y 220..299) is green, not yellow.
- Input change mid-frame: toggle target[2] at v=100. The display is unchanged until the frame after the next frame_start.
- Border (GRID_BORDER_EN defined): pixel (100,60) is white. Pixel (101,61) has the cell colour.
